// File: rtl/score_pkg.sv
// Shared types and defaults for the score digit renderer: sprite geometry,
// transparent colour key, conversion FSM states and the BCD digit type.
package score_pkg;

  localparam int          SPR_W_DEF    = 32;
  localparam int          SPR_H_DEF    = 32;
  localparam logic [23:0] BG_COLOR_DEF = 24'hFFFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } conv_state_t;

  typedef logic [3:0] bcd_digit_t;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9 on the next shift.
  function automatic bcd_digit_t dabble(input bcd_digit_t n);
    return (n >= 4'd5) ? bcd_digit_t'(n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle; done pulses
// SCORE_W+1 cycles after start is accepted. start is ignored while a conversion runs.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int SCORE_W    = 10,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [SCORE_W-1:0]      bin,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int          BW      = 4 * NUM_DIGITS;
  localparam int          CW      = $clog2(SCORE_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

  conv_state_t        state_q, state_d;
  logic [BW-1:0]      bcd_q, bcd_adj;
  logic [SCORE_W-1:0] bin_q, bin_clamped;
  logic [CW-1:0]      cnt_q;

  // Scores beyond the displayable range saturate to all nines.
  assign bin_clamped = (64'(bin) > MAX_VAL) ? SCORE_W'(MAX_VAL) : bin;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[4*i +: 4] = dabble(bcd_q[4*i +: 4]);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(1)) state_d = COMMIT;
      COMMIT: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcd_q <= '0;
      bin_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q <= bin_clamped;
            bcd_q <= '0;
            cnt_q <= CW'(SCORE_W);
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/score_digit_renderer.sv
// Score layer: per-frame BCD conversion plus a 3-cycle pixel pipeline
// (address/select, ROM read, colour key); 1 pixel per clock, never stalls.
module score_digit_renderer
  import score_pkg::*;
#(
  parameter int          NUM_DIGITS = 3,
  parameter int          SCORE_W    = 10,
  parameter int          SPR_W      = SPR_W_DEF,
  parameter int          SPR_H      = SPR_H_DEF,
  parameter int          ORIGIN_X   = 16,
  parameter int          ORIGIN_Y   = 16,
  parameter logic [23:0] BG_COLOR   = BG_COLOR_DEF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  output logic [18:0]        rom_addr,
  output logic [3:0]         rom_sel,
  input  logic [23:0]        rom_data,
  output logic               pix_valid,
  output logic [23:0]        pix_rgb,
  output logic               bcd_ready
);

  localparam int                 XB    = $clog2(SPR_W);
  localparam int                 SLW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic signed [11:0] X_LIM = 12'(NUM_DIGITS * SPR_W);
  localparam logic signed [11:0] Y_LIM = 12'(SPR_H);

  logic [4*NUM_DIGITS-1:0] conv_bcd, disp_q;
  logic                    conv_done;

  bin2bcd_seq #(
    .SCORE_W    (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .start   (frame_start),
    .bin     (score_in),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  // Display digits only move on commit, so a frame never shows a half-updated score.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      disp_q    <= '0;
      bcd_ready <= 1'b0;
    end else begin
      bcd_ready <= conv_done;
      if (conv_done) disp_q <= conv_bcd;
    end
  end

  logic signed [11:0] rx, ry;
  logic [SLW-1:0]     slot;
  logic               in_box, blank, lz_run, hit0;
  bcd_digit_t         cur_digit;
  logic [18:0]        addr0;

  assign rx     = 12'(DrawX) - 12'(ORIGIN_X);
  assign ry     = 12'(DrawY) - 12'(ORIGIN_Y);
  assign in_box = (rx >= 12'sd0) && (rx < X_LIM) && (ry >= 12'sd0) && (ry < Y_LIM);
  assign slot   = SLW'(rx[11:XB]);
  assign addr0  = 19'(ry[9:0]) * 19'(SPR_W) + 19'(rx[XB-1:0]);

  // Slot 0 is the most significant digit; a slot is blank while every digit up to it is zero.
  always_comb begin
    cur_digit = '0;
    blank     = 1'b0;
    lz_run    = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      lz_run = lz_run && (disp_q[4*(NUM_DIGITS-1-d) +: 4] == 4'd0);
      if (SLW'(d) == slot) begin
        cur_digit = disp_q[4*(NUM_DIGITS-1-d) +: 4];
        blank     = lz_run && (d != NUM_DIGITS - 1);
      end
    end
  end

  assign hit0 = in_box && !blank;

  logic hit_d1, hit_d2, opaque;

  assign opaque = hit_d2 && (rom_data != BG_COLOR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      rom_sel   <= '0;
      hit_d1    <= 1'b0;
      hit_d2    <= 1'b0;
      pix_valid <= 1'b0;
      pix_rgb   <= '0;
    end else begin
      rom_addr  <= hit0 ? addr0 : '0;
      rom_sel   <= hit0 ? cur_digit : '0;
      hit_d1    <= hit0;
      hit_d2    <= hit_d1;
      pix_valid <= opaque;
      pix_rgb   <= opaque ? rom_data : '0;
    end
  end

endmodule
